// File: rtl/pong_pkg.sv
// Shared Pong types: rally states, BCD digit/score types, player encoding, BCD increment helper.
package pong_pkg;

    typedef enum logic [1:0] {
        StWait,
        StPlay,
        StOver
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd2_t;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Tens never wraps: scores stay below 100.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score counter with synchronous clear and increment enable.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       inc_i,
    output bcd_digit_t tens_o,
    output bcd_digit_t ones_o,
    output bcd2_t      nxt_o
);

    bcd2_t score_q, score_d;

    assign nxt_o = bcd_inc(score_q);

    always_comb begin
        score_d = score_q;
        if (clr_i) begin
            score_d = '0;
        end else if (inc_i) begin
            score_d = nxt_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign tens_o = score_q.tens;
    assign ones_o = score_q.ones;

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: per-player BCD scores plus the serve-delay / play / game-over sequencer.
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       point_left,
    input  logic       point_right,
    input  logic       new_game,
    output bcd_digit_t left_tens,
    output bcd_digit_t left_ones,
    output bcd_digit_t right_tens,
    output bcd_digit_t right_ones,
    output logic       serve,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned CntW = $clog2(SERVE_DELAY + 1);
    localparam logic [CntW-1:0] CntReload = CntW'(SERVE_DELAY - 1);
    localparam bcd2_t WinBcd = '{
        tens: bcd_digit_t'(WIN_SCORE / 10),
        ones: bcd_digit_t'(WIN_SCORE % 10)
    };

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            serve_q, serve_d;
    logic            dir_q, dir_d;
    logic            over_q, over_d;
    logic            winner_q, winner_d;
    logic            clr, inc_left, inc_right;
    bcd2_t           left_nxt, right_nxt;

    bcd_counter2 u_left (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr),
        .inc_i  (inc_left),
        .tens_o (left_tens),
        .ones_o (left_ones),
        .nxt_o  (left_nxt)
    );

    bcd_counter2 u_right (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr),
        .inc_i  (inc_right),
        .tens_o (right_tens),
        .ones_o (right_ones),
        .nxt_o  (right_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        serve_d   = 1'b0;
        dir_d     = dir_q;
        over_d    = over_q;
        winner_d  = winner_q;
        clr       = 1'b0;
        inc_left  = 1'b0;
        inc_right = 1'b0;

        if (new_game) begin
            clr      = 1'b1;
            state_d  = StWait;
            cnt_d    = CntReload;
            dir_d    = 1'b0;
            over_d   = 1'b0;
            winner_d = 1'b0;
        end else begin
            unique case (state_q)
                StWait: begin
                    if (cnt_q == '0) begin
                        serve_d = 1'b1;
                        state_d = StPlay;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StPlay: begin
                    // Simultaneous points cancel out and the rally continues.
                    if (point_left && !point_right) begin
                        inc_left = 1'b1;
                        if (left_nxt == WinBcd) begin
                            state_d  = StOver;
                            over_d   = 1'b1;
                            winner_d = LEFT;
                        end else begin
                            state_d = StWait;
                            cnt_d   = CntReload;
                            dir_d   = RIGHT;
                        end
                    end else if (point_right && !point_left) begin
                        inc_right = 1'b1;
                        if (right_nxt == WinBcd) begin
                            state_d  = StOver;
                            over_d   = 1'b1;
                            winner_d = RIGHT;
                        end else begin
                            state_d = StWait;
                            cnt_d   = CntReload;
                            dir_d   = LEFT;
                        end
                    end
                end
                StOver: begin
                end
                default: begin
                    state_d = StWait;
                    cnt_d   = CntReload;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StWait;
            cnt_q    <= CntReload;
            serve_q  <= 1'b0;
            dir_q    <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            serve_q  <= serve_d;
            dir_q    <= dir_d;
            over_q   <= over_d;
            winner_q <= winner_d;
        end
    end

    assign serve     = serve_q;
    assign serve_dir = dir_q;
    assign game_over = over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with SERVE_DELAY=4, WIN_SCORE=15.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       point_left = 1'b0;
    logic       point_right = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] left_tens, left_ones, right_tens, right_ones;
    logic       serve, serve_dir, game_over, winner;

    int n_cmp = 0;
    int n_err = 0;

    score_keeper #(
        .WIN_SCORE   (15),
        .SERVE_DELAY (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .point_left  (point_left),
        .point_right (point_right),
        .new_game    (new_game),
        .left_tens   (left_tens),
        .left_ones   (left_ones),
        .right_tens  (right_tens),
        .right_ones  (right_ones),
        .serve       (serve),
        .serve_dir   (serve_dir),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve must stay low for n-1 edges and be high after the n-th.
    task automatic expect_serve(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            step();
            check_eq(tag, 32'(serve), (i == n) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic score(input logic left);
        point_left  = left;
        point_right = ~left;
        step();
        point_left  = 1'b0;
        point_right = 1'b0;
    endtask

    task automatic score_and_serve(input logic left);
        score(left);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 4) check_eq("rally_serve", 32'(serve), 32'd1);
        end
    endtask

    task automatic check_digits(input string tag, input int lt, input int lo,
                                input int rt, input int ro);
        check_eq({tag, "_lt"}, 32'(left_tens), 32'(lt));
        check_eq({tag, "_lo"}, 32'(left_ones), 32'(lo));
        check_eq({tag, "_rt"}, 32'(right_tens), 32'(rt));
        check_eq({tag, "_ro"}, 32'(right_ones), 32'(ro));
    endtask

    initial begin
        // 1: reset, then serve 4 edges later, one cycle wide
        step();
        check_digits("rst", 0, 0, 0, 0);
        check_eq("rst_serve", 32'(serve), 32'd0);
        check_eq("rst_dir", 32'(serve_dir), 32'd0);
        check_eq("rst_over", 32'(game_over), 32'd0);
        check_eq("rst_winner", 32'(winner), 32'd0);
        reset = 1'b0;
        expect_serve("first_serve", 4);
        check_eq("first_serve_dir", 32'(serve_dir), 32'd0);

        // 2: left point, right point during WAIT ignored
        score(1'b1);
        check_eq("pl_left_ones", 32'(left_ones), 32'd1);
        check_eq("pl_dir", 32'(serve_dir), 32'd1);
        check_eq("pl_serve_low", 32'(serve), 32'd0);
        score(1'b0);
        check_eq("wait_ignore_right", 32'(right_ones), 32'd0);
        expect_serve("serve_after_point", 3);
        step();
        check_eq("serve_one_wide", 32'(serve), 32'd0);

        // 4: simultaneous points in PLAY
        point_left  = 1'b1;
        point_right = 1'b1;
        step();
        point_left  = 1'b0;
        point_right = 1'b0;
        check_digits("both", 0, 1, 0, 0);
        check_eq("both_serve", 32'(serve), 32'd0);
        score(1'b0);
        check_eq("still_play_right", 32'(right_ones), 32'd1);
        check_eq("still_play_dir", 32'(serve_dir), 32'd0);
        expect_serve("serve_after_right", 4);

        // 3: left to 9, roll to 10, then win at 15
        for (int i = 0; i < 8; i++) score_and_serve(1'b1);
        check_digits("at9", 0, 9, 0, 1);
        score_and_serve(1'b1);
        check_digits("at10", 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) score_and_serve(1'b1);
        check_digits("at14", 1, 4, 0, 1);
        check_eq("at14_over", 32'(game_over), 32'd0);
        score(1'b1);
        check_digits("win", 1, 5, 0, 1);
        check_eq("win_over", 32'(game_over), 32'd1);
        check_eq("win_winner", 32'(winner), 32'd0);
        for (int i = 0; i < 6; i++) begin
            point_left  = (i % 2) == 0;
            point_right = (i % 2) == 1;
            step();
            check_eq("over_no_serve", 32'(serve), 32'd0);
        end
        point_left  = 1'b0;
        point_right = 1'b0;
        check_digits("over_frozen", 1, 5, 0, 1);
        check_eq("over_held", 32'(game_over), 32'd1);

        // 5: new_game overrides a point in OVER
        new_game    = 1'b1;
        point_right = 1'b1;
        step();
        new_game    = 1'b0;
        point_right = 1'b0;
        check_digits("ng", 0, 0, 0, 0);
        check_eq("ng_over", 32'(game_over), 32'd0);
        check_eq("ng_winner", 32'(winner), 32'd0);
        check_eq("ng_dir", 32'(serve_dir), 32'd0);
        expect_serve("ng_serve", 4);
        check_eq("ng_serve_dir", 32'(serve_dir), 32'd0);

        // 6: reset on the terminal-count cycle suppresses serve and zeroes scores
        score(1'b1);
        check_eq("pre_rst_left", 32'(left_ones), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("pre_rst_no_serve", 32'(serve), 32'd0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("tc_rst_serve", 32'(serve), 32'd0);
        check_digits("mid_rst", 0, 0, 0, 0);
        check_eq("mid_rst_dir", 32'(serve_dir), 32'd0);
        expect_serve("rst_reload_serve", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
